// File: rtl/add8_serial_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and
// the width of the single ripple-carry stage.
package add_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add8_serial_add4.sv
// 4-bit ripple-carry adder assembled from 1-bit full adders; the one
// arithmetic stage that the serial adder reuses for every nibble.
module add4
  import add_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] sum,
  output logic              cout
);

  logic [NIBBLE:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < NIBBLE; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign cout = c_s[NIBBLE];

endmodule

// File: rtl/add8_serial.sv
// Nibble-serial adder: accepts operands over valid/ready, adds one nibble
// per clock low nibble first, then holds sum and flags until taken.
module add8_serial
  import add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSTEP = WIDTH / NIBBLE;
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int SHW   = SW + 2;

  state_t           state_r;
  logic [SW-1:0]    step_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic             carry_r;

  logic [SHW-1:0]    shamt_s;
  logic [NIBBLE-1:0] nib_a_s;
  logic [NIBBLE-1:0] nib_b_s;
  logic [NIBBLE-1:0] st_sum_s;
  logic              st_cout_s;
  logic [WIDTH-1:0]  acc_next_s;
  logic              last_s;

  // Select the active nibble and merge the stage result into the accumulator
  always_comb begin
    shamt_s    = {step_r, 2'b00};
    nib_a_s    = NIBBLE'(a_r >> shamt_s);
    nib_b_s    = NIBBLE'(b_r >> shamt_s);
    acc_next_s = acc_r | (WIDTH'(st_sum_s) << shamt_s);
    last_s     = (step_r == SW'(NSTEP - 1));
  end

  add4 u_add4 (
    .a    (nib_a_s),
    .b    (nib_b_s),
    .cin  (carry_r),
    .sum  (st_sum_s),
    .cout (st_cout_s)
  );

  // Handshake flags decode straight from the state register
  assign in_ready  = (state_r == IDLE) && !rst;
  assign out_valid = (state_r == DONE);

  // FSM, operand capture, nibble sequencing and result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      step_r  <= '0;
      a_r     <= '0;
      b_r     <= '0;
      acc_r   <= '0;
      carry_r <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            // cin rides in the carry register so nibble 0 needs no special path
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            acc_r   <= '0;
            step_r  <= '0;
            state_r <= BUSY;
          end
        end
        BUSY: begin
          acc_r   <= acc_next_s;
          carry_r <= st_cout_s;
          if (last_s) begin
            sum     <= acc_next_s;
            cout    <= st_cout_s;
            ovf     <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                       (acc_next_s[WIDTH-1] != a_r[WIDTH-1]);
            zero    <= (acc_next_s == '0);
            state_r <= DONE;
          end else begin
            step_r <= step_r + SW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add8_serial.sv
// Directed and randomized self-checking bench for add8_serial (WIDTH=8).
module tb_add8_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       zero;

  int total = 0;
  int bad   = 0;

  add8_serial #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for in_ready, accepts one operation and waits for the result.
  task automatic start_op(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, in_ready}, 32'd1);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = ~va; b = ~vb; cin = ~vc;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 32'd2);
    chk("in_ready_done", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("rel_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [7:0] es, input logic ec,
                        input logic eo, input logic ez);
    start_op(va, vb, vc);
    chk({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
    release_op();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ra, rb, es;
    logic       rc;
    logic [8:0] full;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_rel_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    run_op("basic",   8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
    run_op("nibcarry", 8'h0F, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    run_op("wrap",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("posovf",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("negovf",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    run_op("cinfull", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Backpressure: result held, nothing accepted while DONE
    start_op(8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'hAA; b = 8'h55;
      @(negedge clk);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_sum", {24'd0, sum}, 32'h46);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    release_op();
    @(negedge clk);
    @(negedge clk);
    chk("idle_no_accept", {31'd0, out_valid}, 32'd0);
    chk("idle_retain_sum", {24'd0, sum}, 32'h46);

    // Reset on the edge after accept discards the partial result
    a = 8'h55; b = 8'h11; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sum", {24'd0, sum}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_rel_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_no_valid", {31'd0, out_valid}, 32'd0);
    run_op("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream: one accept every 4 cycles, golden-model results
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      es = full[7:0];
      chk("b2b_ready", {31'd0, in_ready}, 32'd1);
      a = ra; b = rb; cin = rc;
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      chk("b2b_busy_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("b2b_busy_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
      chk("b2b_sum", {24'd0, sum}, {24'd0, es});
      chk("b2b_flags", {29'd0, cout, ovf, zero},
          {29'd0, full[8], (ra[7] == rb[7]) && (es[7] != ra[7]), es == 8'h00});
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add8_serial.md
# add8_serial

Sequential nibble-serial adder, the additive counterpart to the ripple-borrow subtract path of the 8-bit ALU. Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. Sums them one 4-bit nibble per clock through a single 4-bit ripple-carry stage, then presents sum and status flags on a held valid/ready output. It sits beside the subtract datapath and feeds the ALU result mux and flag register.

## Interface
- WIDTH, 8: operand/result width; must be a multiple of 4 and at least 4.
- NSTEP, WIDTH/4: derived nibble count; not overridable.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept; high only in IDLE and while rst low.
- a  in  WIDTH  augend.
- b  in  WIDTH  addend.
- cin  in  1  carry-in to nibble 0.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of MSB.
- ovf  out  1  signed overflow: a[MSB]==b[MSB] and sum[MSB]!=a[MSB].
- zero  out  1  sum == 0.

## Operation
- States: IDLE, BUSY, DONE. Reset forces IDLE, step index 0, carry register 0, sum/cout/ovf/zero 0, out_valid 0.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, cin into operand registers; clear sum register; step=0; go BUSY.
- BUSY: each cycle, the 4-bit stage adds nibble[step] of a and b plus the carry register (cin on step 0).
  - Writes the 4-bit result into sum nibble[step] and updates the carry register.
  - If step==NSTEP-1: load cout from stage carry, compute ovf and zero from the final sum, go DONE. Otherwise step+1.
- DONE: out_valid=1; sum/cout/ovf/zero stable. On out_ready, go IDLE. No acceptance in the same cycle as release.
- Inputs a/b/cin are ignored outside the accept cycle; changing them mid-operation has no effect.
- in_valid held high in BUSY/DONE is not consumed.
- Outputs sum/cout/ovf/zero retain the last result in IDLE until the next completion overwrites them. out_valid alone qualifies them.
- Arithmetic is unsigned modulo 2^WIDTH. Nibble carry chain is strictly sequential, low nibble first.
- rst asserted in any state, including mid-BUSY or DONE with out_ready low: the next edge returns to reset values. The partial result is discarded and no out_valid pulse occurs.

## Timing
- Accept at edge E0. Nibbles are written at edges E1..E(NSTEP). out_valid rises after edge E(NSTEP).
- WIDTH=8: out_valid is high 2 cycles after the accept edge.
- out_valid stays high until the first edge with out_ready=1. It drops after that edge, and in_ready rises at the same time.
- Minimum issue interval: NSTEP+2 cycles (10 → 0 gap none). For WIDTH=8, one op every 4 cycles with out_ready tied high.
- in_ready and out_valid are decoded from registered state only; no combinational path from inputs to them.
- in_ready is 0 during the cycle rst is high.

## Structure
- Shared package add_pkg: state encoding constants (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and NIBBLE=4.
- One sub-module: add4, a 4-bit ripple-carry adder (sum, carry-out, a, b, carry-in). It is built from 1-bit full adders, mirroring the subtract slice structure.
- Top holds the FSM, step counter of width clog2(NSTEP) (minimum 1), operand/sum/carry registers, and flag logic.

## Test plan
- a=0x3C, b=0x05, cin=0 → sum=0x41, cout=0, ovf=0, zero=0; out_valid exactly 2 cycles after accept.
- a=0x0F, b=0x00, cin=1 → sum=0x10 (cross-nibble carry), cout=0; then a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, zero=1, ovf=0.
- a=0x7F, b=0x01 → sum=0x80, ovf=1, cout=0; a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1, zero=1.
- Backpressure: out_ready low 5 cycles after completion → out_valid and sum held constant, in_ready=0 throughout. A changed in_valid/a during the hold is not accepted.
- Reset mid-BUSY (rst on the edge after accept) → next cycle out_valid=0, sum=0, in_ready=1 after rst drops. A new op 0x01+0x01 yields 0x02.
- Back-to-back with out_ready=1 and in_valid=1 continuously → one accept every 4 cycles. Results match the golden model for 1000 random a/b/cin.
